// File: rtl/mul_arbiter_pkg.sv
// Shared definitions for the two-requester multiplier arbiter and its bench.
package mul_arbiter_pkg;

    // FSM states, binary encoded
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_M = 3'd1,
        ST_LOAD_Q = 3'd2,
        ST_WAIT   = 3'd3,
        ST_CAP_LO = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    // Default number of WAIT cycles before an operation is aborted
    localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/mul_arbiter_if.sv
// Request, response and multiplier-side signals of mul_arbiter.
// slave: the arbiter side; master: the environment driving it.
interface mul_arbiter_if;
    logic        req0_valid;
    logic [7:0]  req0_a;
    logic [7:0]  req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_a;
    logic [7:0]  req1_b;
    logic        req1_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_prod;
    logic        rsp_err;
    logic        mul_start;
    logic [7:0]  mul_inbus;
    logic        mul_final;
    logic [8:0]  mul_outbus;
    logic        busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  rsp_ready, mul_final, mul_outbus,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_prod, rsp_err,
        output mul_start, mul_inbus, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output rsp_ready, mul_final, mul_outbus,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_prod, rsp_err,
        input  mul_start, mul_inbus, busy
    );
endinterface

// File: rtl/mul_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: the pointer names the winner of a tie and
// moves to the losing side after every grant.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant,
    output logic       o_gnt_id
);
    logic r_rr;

    // Grant one valid requester, only while enabled
    always_comb begin
        o_grant  = 2'b00;
        o_gnt_id = 1'b0;
        if (i_en) begin
            if (i_valid == 2'b11) begin
                o_grant  = r_rr ? 2'b10 : 2'b01;
                o_gnt_id = r_rr;
            end else if (i_valid[0]) begin
                o_grant  = 2'b01;
            end else if (i_valid[1]) begin
                o_grant  = 2'b10;
                o_gnt_id = 1'b1;
            end
        end
    end

    // Point at the non-granted requester after each grant
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr <= 1'b0;
        end else if (|o_grant) begin
            r_rr <= ~o_gnt_id;
        end
    end
endmodule

// File: rtl/mul_arbiter.sv
// Arbitrates two requesters onto one radix-4 Booth multiplier: loads the
// operands serially, waits for the done flag (with timeout), assembles the
// 16-bit product from two result words and holds it until accepted.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    mul_arbiter_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    state_t         r_state;
    state_t         w_next;
    logic [7:0]     r_a;
    logic [7:0]     r_b;
    logic           r_id;
    logic           r_err;
    logic [15:0]    r_prod;
    logic [CW-1:0]  r_cnt;

    logic [1:0]     w_grant;
    logic           w_gnt_id;
    logic           w_take;
    logic           w_idle;
    logic           w_timeout;
    logic           w_start;
    logic [7:0]     w_inbus;
    logic           w_rsp_valid;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_take    = |w_grant;
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    rr_arb2 u_arb (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_en     (w_idle),
        .i_valid  ({bus.req1_valid, bus.req0_valid}),
        .o_grant  (w_grant),
        .o_gnt_id (w_gnt_id)
    );

    assign bus.req0_ready = w_grant[0];
    assign bus.req1_ready = w_grant[1];
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_prod   = r_prod;
    assign bus.rsp_err    = r_err;
    assign bus.mul_start  = w_start;
    assign bus.mul_inbus  = w_inbus;
    assign bus.busy       = ~w_idle;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and state-decoded outputs; mul_final only matters in WAIT
    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_inbus     = 8'h00;
        w_rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_take) w_next = ST_LOAD_M;
            end
            ST_LOAD_M: begin
                w_start = 1'b1;
                w_inbus = r_a;
                w_next  = ST_LOAD_Q;
            end
            ST_LOAD_Q: begin
                w_inbus = r_b;
                w_next  = ST_WAIT;
            end
            ST_WAIT: begin
                w_inbus = r_b;
                if (bus.mul_final) begin
                    w_next = ST_CAP_LO;
                end else if (w_timeout) begin
                    w_next = ST_RESP;
                end
            end
            ST_CAP_LO: begin
                w_next = ST_RESP;
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Operand latch, timeout counter and product assembly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a    <= 8'h00;
            r_b    <= 8'h00;
            r_id   <= 1'b0;
            r_err  <= 1'b0;
            r_prod <= 16'h0000;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_a    <= w_gnt_id ? bus.req1_a : bus.req0_a;
                        r_b    <= w_gnt_id ? bus.req1_b : bus.req0_b;
                        r_id   <= w_gnt_id;
                        r_err  <= 1'b0;
                        r_prod <= 16'h0000;
                    end
                end
                ST_LOAD_Q: begin
                    r_cnt <= '0;
                end
                ST_WAIT: begin
                    // counter stops at the abort value instead of wrapping
                    if (!w_timeout) r_cnt <= r_cnt + CW'(1);
                    if (bus.mul_final) begin
                        r_prod[15:8] <= bus.mul_outbus[7:0];
                    end else if (w_timeout) begin
                        r_err  <= 1'b1;
                        r_prod <= 16'h0000;
                    end
                end
                ST_CAP_LO: begin
                    r_prod[7:0] <= bus.mul_outbus[8:1];
                end
                default: begin
                end
            endcase
        end
    end
endmodule
